// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider. Each channel toggles its clk_out every
// div_a+1 enabled cycles; new divisors are staged in a shadow register and go live at a half-period boundary.
module prog_clock_divider #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 27,
    parameter int RESET_DIV = 49999999,
    localparam int LCH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LCH_W-1:0]  load_ch,
    input  logic [CNT_W-1:0]  load_div,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);

    logic [CNT_W-1:0] cnt_q     [NUM_CH];
    logic [CNT_W-1:0] div_a_q   [NUM_CH];
    logic [CNT_W-1:0] div_s_q   [NUM_CH];
    logic [CNT_W-1:0] div_s_nxt [NUM_CH];
    logic             load_ok;

    // Indices beyond the last channel (possible when NUM_CH is not a power of two) are dropped.
    assign load_ok = load && (32'(load_ch) < NUM_CH);

    // The shadow value as it will stand after this edge, so a load and a
    // same-edge transfer into div_a see the new divisor together.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_s_nxt[i] = div_s_q[i];
            if (load_ok && (load_ch == LCH_W'(i))) begin
                div_s_nxt[i] = load_div;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_s_q[i] <= RST_DIV;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_s_q[i] <= div_s_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_out <= '0;
            tick    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= '0;
                div_a_q[i] <= RST_DIV;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Disabled or realigned channels park low at count zero; sync wins over a terminal count.
                if (!ch_en[i] || sync) begin
                    cnt_q[i]   <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                    div_a_q[i] <= div_s_nxt[i];
                end else if (cnt_q[i] == div_a_q[i]) begin
                    cnt_q[i]   <= '0;
                    clk_out[i] <= ~clk_out[i];
                    tick[i]    <= 1'b1;
                    div_a_q[i] <= div_s_nxt[i];
                end else begin
                    cnt_q[i]   <= cnt_q[i] + CNT_W'(1);
                    tick[i]    <= 1'b0;
                end
            end
        end
    end

endmodule
